// File: rtl/uart_serdbg_monitor.sv
// UART link-health monitor for NCHAN 8N1 lines.
// A fractional accumulator makes a 16x oversample tick. Each line is
// synchronised, decoded by its own FSM, and keeps saturating byte and
// framing-error counters. A registered read-select port exposes one
// channel's counters and last good byte.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   rx_i              raw UART lines (asynchronous to clk_i)
//   clr_counts_i      one-cycle pulse clearing all counters
//   byte_valid_o      per-channel one-cycle strobe: byte received
//   byte_data_o       per-channel last received byte (8 bits each)
//   rd_sel_i          readback channel select
//   rd_byte_o         last good byte of the selected channel
//   rd_bytes_o        byte count of the selected channel
//   rd_errs_o         framing-error count of the selected channel
//   tick_16x_o        oversample tick
module uart_serdbg_monitor #(
  parameter int unsigned NCHAN    = 5,
  parameter int unsigned ACC_BITS = 10,
  parameter int unsigned TICK_ADD = 82,
  parameter int unsigned CNT_BITS = 16,
  localparam int unsigned SelW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NCHAN-1:0]     rx_i,
  input  logic                 clr_counts_i,
  output logic [NCHAN-1:0]     byte_valid_o,
  output logic [8*NCHAN-1:0]   byte_data_o,
  input  logic [SelW-1:0]      rd_sel_i,
  output logic [7:0]           rd_byte_o,
  output logic [CNT_BITS-1:0]  rd_bytes_o,
  output logic [CNT_BITS-1:0]  rd_errs_o,
  output logic                 tick_16x_o
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;

  localparam logic [CNT_BITS-1:0] CntMax = '1;

  // Tick generator: the carry out of the low ACC_BITS bits is the tick.
  logic [ACC_BITS:0] acc_q, acc_d;
  logic              tick;

  assign acc_d      = {1'b0, acc_q[ACC_BITS-1:0]} + (ACC_BITS + 1)'(TICK_ADD);
  assign tick       = acc_q[ACC_BITS];
  assign tick_16x_o = tick;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  // 2-FF synchronisers, reset to the idle (high) line level.
  logic [NCHAN-1:0] rx_meta_q, rx_sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= '1;
      rx_sync_q <= '1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  logic [7:0]          data_arr  [NCHAN];
  logic [CNT_BITS-1:0] bytes_arr [NCHAN];
  logic [CNT_BITS-1:0] errs_arr  [NCHAN];

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          sr_q, sr_d;
    logic [7:0]          data_q;
    logic                valid_q, err_q;
    logic                got_byte, got_err;
    logic [CNT_BITS-1:0] bytes_q, bytes_d, errs_q, errs_d;
    logic                rx;

    assign rx = rx_sync_q[g];

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      sr_d     = sr_q;
      got_byte = 1'b0;
      got_err  = 1'b0;
      if (tick) begin
        unique case (state_q)
          StIdle: begin
            if (!rx) begin
              state_d = StStart;
              cnt_d   = '0;
            end
          end
          StStart: begin
            cnt_d = cnt_q + 4'd1;
            // Mid start bit: still low means a real frame, else a glitch.
            if (cnt_q == 4'd7) begin
              if (!rx) begin
                state_d = StData;
                cnt_d   = '0;
                bit_d   = '0;
              end else begin
                state_d = StIdle;
              end
            end
          end
          StData: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              sr_d  = {rx, sr_q[7:1]};
              bit_d = bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                state_d = StStop;
                cnt_d   = '0;
              end
            end
          end
          StStop: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              if (rx) begin
                got_byte = 1'b1;
                state_d  = StIdle;
              end else begin
                got_err = 1'b1;
                state_d = StWaitHi;
              end
            end
          end
          StWaitHi: begin
            // A held break stays here, so it counts as one error.
            if (rx) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end

    // Counters increment the cycle after the strobe so that a clear issued
    // while the strobe is visible coincides with the increment and wins.
    always_comb begin
      bytes_d = bytes_q;
      errs_d  = errs_q;
      if (clr_counts_i) begin
        bytes_d = '0;
        errs_d  = '0;
      end else begin
        if (valid_q && bytes_q != CntMax) bytes_d = bytes_q + 1'b1;
        if (err_q && errs_q != CntMax)    errs_d  = errs_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        bit_q   <= '0;
        sr_q    <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
        bytes_q <= '0;
        errs_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        bit_q   <= bit_d;
        sr_q    <= sr_d;
        valid_q <= got_byte;
        err_q   <= got_err;
        bytes_q <= bytes_d;
        errs_q  <= errs_d;
        if (got_byte) data_q <= sr_q;
      end
    end

    assign byte_valid_o[g]       = valid_q;
    assign byte_data_o[8*g +: 8] = data_q;
    assign data_arr[g]           = data_q;
    assign bytes_arr[g]          = bytes_q;
    assign errs_arr[g]           = errs_q;
  end

  // Registered readback; out-of-range selects read as zero.
  logic [7:0]          rd_byte_d;
  logic [CNT_BITS-1:0] rd_bytes_d, rd_errs_d;

  always_comb begin
    rd_byte_d  = '0;
    rd_bytes_d = '0;
    rd_errs_d  = '0;
    if (32'(rd_sel_i) < NCHAN) begin
      rd_byte_d  = data_arr[rd_sel_i];
      rd_bytes_d = bytes_arr[rd_sel_i];
      rd_errs_d  = errs_arr[rd_sel_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_byte_o  <= '0;
      rd_bytes_o <= '0;
      rd_errs_o  <= '0;
    end else begin
      rd_byte_o  <= rd_byte_d;
      rd_bytes_o <= rd_bytes_d;
      rd_errs_o  <= rd_errs_d;
    end
  end

endmodule

// File: tb/tb_uart_serdbg_monitor.sv
// Self-checking bench for uart_serdbg_monitor (5 channels, 4-bit counters).
// Received bytes are scoreboarded: tasks push expected {chan, byte} entries,
// a monitor queues every observed strobe, and tasks pop and compare.
module tb_uart_serdbg_monitor;

  localparam int NChan   = 5;
  localparam int CntBits = 4;
  localparam int SelW    = 3;
  localparam int BitCyc  = 200;  // 500 kbaud at 100 MHz

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NChan-1:0]     rx  = '1;
  logic                 clr = 1'b0;
  logic [NChan-1:0]     byte_valid;
  logic [8*NChan-1:0]   byte_data;
  logic [SelW-1:0]      rd_sel = '0;
  logic [7:0]           rd_byte;
  logic [CntBits-1:0]   rd_bytes, rd_errs;
  logic                 tick;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];

  uart_serdbg_monitor #(
    .NCHAN(NChan), .ACC_BITS(10), .TICK_ADD(82), .CNT_BITS(CntBits)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .clr_counts_i(clr),
    .byte_valid_o(byte_valid), .byte_data_o(byte_data), .rd_sel_i(rd_sel),
    .rd_byte_o(rd_byte), .rd_bytes_o(rd_bytes), .rd_errs_o(rd_errs),
    .tick_16x_o(tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NChan; c++) begin
        if (byte_valid[c]) obs_q.push_back({3'(c), byte_data[8*c +: 8]});
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = '1;
    clr = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic send_byte(input int ch, input logic [7:0] d, input logic stop_bit);
    rx[ch] = 1'b0;
    wait_cyc(BitCyc);
    for (int i = 0; i < 8; i++) begin
      rx[ch] = d[i];
      wait_cyc(BitCyc);
    end
    rx[ch] = stop_bit;
    wait_cyc(BitCyc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(4);
    total_cnt++; if (tick !== 1'b0) $display("FAIL rst_tick got %b want 0", tick); else pass_cnt++;
    total_cnt++; if (byte_valid !== '0) $display("FAIL rst_valid got %h want 0", byte_valid); else pass_cnt++;
    total_cnt++; if (byte_data !== '0) $display("FAIL rst_data got %h want 0", byte_data); else pass_cnt++;
    total_cnt++; if (rd_bytes !== '0) $display("FAIL rst_rd_bytes got %0d want 0", rd_bytes); else pass_cnt++;
    rst = 1'b0;
    wait_cyc(3);
    total_cnt++; if (rd_byte !== '0) $display("FAIL rst_rd_byte got %h want 0", rd_byte); else pass_cnt++;
    total_cnt++; if (rd_errs !== '0) $display("FAIL rst_rd_errs got %0d want 0", rd_errs); else pass_cnt++;
  endtask

  task automatic test_tick_rate();
    int   ticks = 0;
    int   adj   = 0;
    logic prev  = 1'b0;
    do_reset();
    repeat (10240) begin
      @(negedge clk);
      if (tick && prev) adj++;
      if (tick) ticks++;
      prev = tick;
    end
    total_cnt++; if (ticks != 820) $display("FAIL tick_count got %0d want 820", ticks); else pass_cnt++;
    total_cnt++; if (adj != 0) $display("FAIL tick_adjacent got %0d want 0", adj); else pass_cnt++;
  endtask

  task automatic test_good_byte();
    logic [10:0] e, o;
    do_reset();
    exp_q.push_back({3'd0, 8'hA5});
    send_byte(0, 8'hA5, 1'b1);
    wait_cyc(20);
    rd_sel = 3'd0;
    wait_cyc(2);
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL good_strobes got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL good_sb got %h want %h", o, e); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
    total_cnt++; if (byte_data[7:0] !== 8'hA5) $display("FAIL good_data got %h want a5", byte_data[7:0]); else pass_cnt++;
    total_cnt++; if (byte_data[39:8] !== '0) $display("FAIL good_others got %h want 0", byte_data[39:8]); else pass_cnt++;
    total_cnt++; if (rd_bytes !== 4'd1) $display("FAIL good_rd_bytes got %0d want 1", rd_bytes); else pass_cnt++;
    total_cnt++; if (rd_errs !== 4'd0) $display("FAIL good_rd_errs got %0d want 0", rd_errs); else pass_cnt++;
    total_cnt++; if (rd_byte !== 8'hA5) $display("FAIL good_rd_byte got %h want a5", rd_byte); else pass_cnt++;
  endtask

  task automatic test_framing();
    logic [10:0] e, o;
    do_reset();
    rd_sel = 3'd4;
    send_byte(4, 8'h3C, 1'b0);
    wait_cyc(10000);  // 100 us break
    total_cnt++; if (rd_errs !== 4'd1) $display("FAIL frm_errs got %0d want 1", rd_errs); else pass_cnt++;
    total_cnt++; if (rd_bytes !== 4'd0) $display("FAIL frm_bytes got %0d want 0", rd_bytes); else pass_cnt++;
    total_cnt++; if (obs_q.size() != 0) $display("FAIL frm_strobe got %0d want 0", obs_q.size()); else pass_cnt++;
    total_cnt++; if (byte_data[39:32] !== 8'h00) $display("FAIL frm_data got %h want 00", byte_data[39:32]); else pass_cnt++;
    rx[4] = 1'b1;
    wait_cyc(400);
    exp_q.push_back({3'd4, 8'h55});
    send_byte(4, 8'h55, 1'b1);
    wait_cyc(20);
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL frm_strobes got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL frm_sb got %h want %h", o, e); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
    total_cnt++; if (rd_bytes !== 4'd1) $display("FAIL frm_bytes2 got %0d want 1", rd_bytes); else pass_cnt++;
    total_cnt++; if (rd_errs !== 4'd1) $display("FAIL frm_errs2 got %0d want 1", rd_errs); else pass_cnt++;
  endtask

  task automatic test_glitch();
    do_reset();
    rd_sel = 3'd2;
    rx[2] = 1'b0;
    wait_cyc(37);  // about 3 ticks
    rx[2] = 1'b1;
    wait_cyc(2500);
    total_cnt++; if (obs_q.size() != 0) $display("FAIL glitch_strobe got %0d want 0", obs_q.size()); else pass_cnt++;
    total_cnt++; if (rd_bytes !== 4'd0) $display("FAIL glitch_bytes got %0d want 0", rd_bytes); else pass_cnt++;
    total_cnt++; if (rd_errs !== 4'd0) $display("FAIL glitch_errs got %0d want 0", rd_errs); else pass_cnt++;
    obs_q.delete();
  endtask

  task automatic test_saturation();
    logic [10:0] e, o;
    logic [7:0]  d;
    logic        seen = 1'b0;
    do_reset();
    rd_sel = 3'd1;
    for (int i = 0; i < 20; i++) begin
      d = 8'(i * 37 + 5);
      exp_q.push_back({3'd1, d});
      send_byte(1, d, 1'b1);
      wait_cyc(10);
    end
    wait_cyc(5);
    total_cnt++; if (rd_bytes !== 4'd15) $display("FAIL sat_bytes got %0d want 15", rd_bytes); else pass_cnt++;
    total_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL sat_strobes got %0d want %0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL sat_sb got %h want %h", o, e); else pass_cnt++;
    end
    exp_q.delete(); obs_q.delete();
    fork
      send_byte(1, 8'hC3, 1'b1);
      begin : clr_on_strobe
        int n = 0;
        while (!seen && n < 3000) begin
          @(negedge clk);
          n++;
          if (byte_valid[1]) seen = 1'b1;
        end
        if (seen) begin
          clr = 1'b1;
          @(posedge clk);
          #1;
          clr = 1'b0;
        end
      end
    join
    wait_cyc(5);
    total_cnt++; if (seen !== 1'b1) $display("FAIL clr_strobe_seen got %b want 1", seen); else pass_cnt++;
    total_cnt++; if (rd_bytes !== 4'd0) $display("FAIL clr_bytes got %0d want 0", rd_bytes); else pass_cnt++;
    send_byte(1, 8'h3A, 1'b1);
    wait_cyc(5);
    total_cnt++; if (rd_bytes !== 4'd1) $display("FAIL clr_next got %0d want 1", rd_bytes); else pass_cnt++;
    total_cnt++; if (rd_byte !== 8'h3A) $display("FAIL clr_rd_byte got %h want 3a", rd_byte); else pass_cnt++;
    rd_sel = 3'd5;
    wait_cyc(2);
    total_cnt++; if (rd_bytes !== 4'd0) $display("FAIL sel5_bytes got %0d want 0", rd_bytes); else pass_cnt++;
    rd_sel = 3'd7;
    wait_cyc(2);
    total_cnt++; if (rd_byte !== 8'h00) $display("FAIL sel7_byte got %h want 00", rd_byte); else pass_cnt++;
    obs_q.delete();
  endtask

  task automatic test_reset_midframe();
    logic [10:0] e, o;
    do_reset();
    rd_sel = 3'd3;
    send_byte(3, 8'h5A, 1'b1);
    wait_cyc(20);
    total_cnt++; if (rd_bytes !== 4'd1) $display("FAIL mid_pre_bytes got %0d want 1", rd_bytes); else pass_cnt++;
    obs_q.delete();
    // 0xF0: line is high from data bit 4 onward, so the aborted frame
    // cannot look like a new start once reset releases.
    fork
      send_byte(3, 8'hF0, 1'b1);
      begin
        wait_cyc(1050);
        rst = 1'b1;
        #1;
        total_cnt++; if (byte_data !== '0) $display("FAIL mid_data got %h want 0", byte_data); else pass_cnt++;
        total_cnt++; if (rd_bytes !== '0) $display("FAIL mid_rd_bytes got %0d want 0", rd_bytes); else pass_cnt++;
        total_cnt++; if (rd_byte !== '0) $display("FAIL mid_rd_byte got %h want 0", rd_byte); else pass_cnt++;
        total_cnt++; if (byte_valid !== '0 || tick !== 1'b0) $display("FAIL mid_valid_tick got %h/%b want 0/0", byte_valid, tick); else pass_cnt++;
        wait_cyc(3);
        rst = 1'b0;
      end
    join
    wait_cyc(50);
    total_cnt++; if (obs_q.size() != 0) $display("FAIL mid_abort_strobe got %0d want 0", obs_q.size()); else pass_cnt++;
    obs_q.delete();
    exp_q.push_back({3'd3, 8'h81});
    send_byte(3, 8'h81, 1'b1);
    wait_cyc(20);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total_cnt++;
      if (o !== e) $display("FAIL mid_sb got %h want %h", o, e); else pass_cnt++;
    end
    total_cnt++; if (exp_q.size() != 0 || obs_q.size() != 0) $display("FAIL mid_sb_left got %0d/%0d want 0/0", exp_q.size(), obs_q.size()); else pass_cnt++;
    exp_q.delete(); obs_q.delete();
    total_cnt++; if (rd_bytes !== 4'd1) $display("FAIL mid_bytes got %0d want 1", rd_bytes); else pass_cnt++;
    total_cnt++; if (rd_errs !== 4'd0) $display("FAIL mid_errs got %0d want 0", rd_errs); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_tick_rate();
    test_good_byte();
    test_framing();
    test_glitch();
    test_saturation();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
